// File: rtl/spi_preamp_adc_ctrl.sv
// spi_preamp_adc_ctrl
// One SPI master shared by the LTC6912 preamp and the LTC1407A dual ADC.
// It loads the gain word after reset and whenever a new word is requested.
// It also starts conversions at a fixed period. Each conversion captures both
// channels and updates a hysteresis comparator per channel.
`timescale 1ns/1ps

module spi_preamp_adc_ctrl #(
  parameter int          CLK_DIV       = 4,
  parameter int          SAMPLE_W      = 14,
  parameter int          SAMPLE_PERIOD = 1000,
  parameter logic [7:0]  INIT_GAIN     = 8'h11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          gain_a,
  input  logic [3:0]          gain_b,
  input  logic                gain_wr,
  input  logic [SAMPLE_W-1:0] thr_hi,
  input  logic [SAMPLE_W-1:0] thr_lo,
  input  logic                spi_miso,
  output logic                spi_sck,
  output logic                spi_mosi,
  output logic                amp_cs_n,
  output logic                ad_conv,
  output logic [SAMPLE_W-1:0] sample_a,
  output logic [SAMPLE_W-1:0] sample_b,
  output logic                sample_valid,
  output logic [1:0]          wave,
  output logic                gain_done,
  output logic                overrun
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_GAIN = 2'd1,
    ST_IDLE = 2'd2,
    ST_CONV = 2'd3
  } state_t;

  localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRAME_W = 34;

  // Half-period indices. A gain load is 16 halves.
  // A conversion is 2 ad_conv halves followed by 68 SCK halves.
  localparam logic [6:0] GAIN_LAST_HALF = 7'd15;
  localparam logic [6:0] CONV_LAST_HALF = 7'd69;
  localparam logic [6:0] CONV_SCK_HALF  = 7'd2;

  state_t              state;
  state_t              state_next;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick_wrap;
  logic [DIV_W-1:0]    div_cnt;
  logic [6:0]          half_cnt;
  logic                half_end;
  logic                gain_last;
  logic                conv_last;
  logic                sample_pt;
  logic                take_gain;
  logic                take_conv;
  logic [7:0]          gain_word;
  logic [7:0]          shadow_word;
  logic                gain_pending;
  logic                conv_pending;
  logic [FRAME_W-1:0]  frame;
  logic [SAMPLE_W-1:0] frame_sample [2];
  logic [1:0]          wave_next;
  logic [2:0]          bit_idx;

  assign tick_wrap = (tick_cnt == TICK_W'(SAMPLE_PERIOD - 1));
  assign half_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign gain_last = (state == ST_GAIN) && half_end && (half_cnt == GAIN_LAST_HALF);
  assign conv_last = (state == ST_CONV) && half_end && (half_cnt == CONV_LAST_HALF);
  // MISO is sampled on the clk edge that ends a low SCK half, which is where SCK rises.
  assign sample_pt = (state == ST_CONV) && half_end && (half_cnt >= CONV_SCK_HALF) && !half_cnt[0];
  assign take_gain = (state == ST_IDLE) && gain_pending;
  assign take_conv = (state == ST_IDLE) && !gain_pending && conv_pending;
  assign bit_idx   = half_cnt[3:1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_next;
  end

  // Next-state logic: a pending gain load always goes ahead of a pending conversion
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: state_next = ST_GAIN;
      ST_GAIN: if (gain_last) state_next = ST_IDLE;
      ST_IDLE: begin
        if (gain_pending)      state_next = ST_GAIN;
        else if (conv_pending) state_next = ST_CONV;
      end
      ST_CONV: if (conv_last) state_next = ST_IDLE;
      default: state_next = ST_INIT;
    endcase
  end

  // Output decode: SCK is low in even halves and high in odd halves, and it stays low during ad_conv
  always_comb begin
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    amp_cs_n = 1'b1;
    ad_conv  = 1'b0;
    case (state)
      ST_GAIN: begin
        amp_cs_n = 1'b0;
        spi_sck  = half_cnt[0];
        spi_mosi = gain_word[3'd7 - bit_idx];
      end
      ST_CONV: begin
        ad_conv = (half_cnt < CONV_SCK_HALF);
        spi_sck = (half_cnt >= CONV_SCK_HALF) && half_cnt[0];
      end
      default: ;
    endcase
  end

  // Free-running conversion period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tick_cnt <= '0;
    else if (tick_wrap) tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + 1'b1;
  end

  // SCK timing counters: they restart on every state change and run only while shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      half_cnt <= '0;
    end else if (state_next != state || !(state == ST_GAIN || state == ST_CONV)) begin
      div_cnt  <= '0;
      half_cnt <= '0;
    end else if (half_end) begin
      div_cnt  <= '0;
      half_cnt <= half_cnt + 7'd1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Gain word handling: requests land in a shadow and are copied only when a load starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_word    <= '0;
      shadow_word  <= '0;
      gain_pending <= 1'b0;
      gain_done    <= 1'b0;
    end else begin
      if (state == ST_INIT) gain_word <= INIT_GAIN;
      else if (take_gain)   gain_word <= shadow_word;
      if (gain_wr) shadow_word <= {gain_b, gain_a};
      // A request arriving in the same cycle as a take stays pending for the next load
      gain_pending <= gain_wr | (gain_pending & ~take_gain);
      gain_done    <= gain_last;
    end
  end

  // Conversion request tracking; a tick arriving while a request is still unserved is sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_pending <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      conv_pending <= tick_wrap | (conv_pending & ~take_conv);
      if (tick_wrap && conv_pending && !take_conv) overrun <= 1'b1;
    end
  end

  // ADC frame shift register, filled MSB first so the bit received first ends up in the top bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         frame <= '0;
    else if (sample_pt) frame <= {frame[FRAME_W-2:0], spi_miso};
  end

  // Frame bit k sits at frame[33-k]: channel A is k=2.., channel B is k=18..
  assign frame_sample[0] = frame[31 -: SAMPLE_W];
  assign frame_sample[1] = frame[15 -: SAMPLE_W];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic wave_nx;
      // Hysteresis on the new sample: the upper test wins, and equality holds the state
      always_comb begin
        wave_nx = wave[gi];
        if ($signed(frame_sample[gi]) > $signed(thr_hi))      wave_nx = 1'b1;
        else if ($signed(frame_sample[gi]) < $signed(thr_lo)) wave_nx = 1'b0;
      end
    end
  endgenerate

  assign wave_next = {g_chan[1].wave_nx, g_chan[0].wave_nx};

  // Publish samples and wave together with the valid pulse at the end of the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_a     <= '0;
      sample_b     <= '0;
      wave         <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= conv_last;
      if (conv_last) begin
        sample_a <= frame_sample[0];
        sample_b <= frame_sample[1];
        wave     <= wave_next;
      end
    end
  end

endmodule

// File: tb/tb_spi_preamp_adc_ctrl.sv
// Directed bench for spi_preamp_adc_ctrl: it checks the gain loads, conversions,
// hysteresis, mid-conversion gain requests, mid-conversion reset and overrun.
`timescale 1ns/1ps

module tb_spi_preamp_adc_ctrl;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rst2_n;
  logic [3:0]   gain_a;
  logic [3:0]   gain_b;
  logic         gain_wr;
  logic [W-1:0] thr_hi;
  logic [W-1:0] thr_lo;
  logic         spi_miso = 1'b0;
  logic         spi_sck, spi_mosi, amp_cs_n, ad_conv, sample_valid, gain_done, overrun;
  logic [W-1:0] sample_a, sample_b;
  logic [1:0]   wave;

  logic         sck2, mosi2, cs2_n, conv2, valid2, done2, overrun2;
  logic [W-1:0] sample_a2, sample_b2;
  logic [1:0]   wave2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_preamp_adc_ctrl #(
    .CLK_DIV(4), .SAMPLE_W(W), .SAMPLE_PERIOD(1000), .INIT_GAIN(8'h11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gain_a(gain_a), .gain_b(gain_b), .gain_wr(gain_wr),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .spi_miso(spi_miso), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .amp_cs_n(amp_cs_n), .ad_conv(ad_conv), .sample_a(sample_a),
    .sample_b(sample_b), .sample_valid(sample_valid), .wave(wave), .gain_done(gain_done),
    .overrun(overrun)
  );

  // Second instance with a too-short period; MISO held high so every sample is -1
  spi_preamp_adc_ctrl #(
    .CLK_DIV(4), .SAMPLE_W(W), .SAMPLE_PERIOD(100), .INIT_GAIN(8'h11)
  ) dut_ovr (
    .clk(clk), .rst_n(rst2_n), .gain_a(4'h0), .gain_b(4'h0), .gain_wr(1'b0),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .spi_miso(1'b1), .spi_sck(sck2),
    .spi_mosi(mosi2), .amp_cs_n(cs2_n), .ad_conv(conv2), .sample_a(sample_a2),
    .sample_b(sample_b2), .sample_valid(valid2), .wave(wave2), .gain_done(done2),
    .overrun(overrun2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: frame {2'b0, A, 2'b0, B, 2'b0}; bit 0 at ad_conv rise, next bit on each SCK fall
  logic [W-1:0] mdl_a = '0;
  logic [W-1:0] mdl_b = '0;
  logic [33:0]  mdl_frame = '0;
  int           mdl_k = 0;
  bit           mdl_act = 1'b0;

  always @(posedge ad_conv or negedge spi_sck) begin
    if (ad_conv) begin
      mdl_frame = {2'b00, mdl_a, 2'b00, mdl_b, 2'b00};
      mdl_k     = 0;
      mdl_act   = 1'b1;
      spi_miso  = mdl_frame[33];
    end else if (mdl_act && amp_cs_n) begin
      if (mdl_k < 33) begin
        mdl_k    = mdl_k + 1;
        spi_miso = mdl_frame[33 - mdl_k];
      end else begin
        mdl_act  = 1'b0;
        spi_miso = 1'b0;
      end
    end
  end

  int           valid2_cnt = 0;
  logic [W-1:0] last_a2 = '0;
  logic [W-1:0] last_b2 = '0;

  always @(negedge clk) begin
    if (valid2 === 1'b1) begin
      valid2_cnt = valid2_cnt + 1;
      last_a2    = sample_a2;
      last_b2    = sample_b2;
    end
  end

  // Watch one gain load: the 64-clk select window, the SCK pattern, the shifted word and gain_done
  task automatic capture_gain(input string tag, input logic [7:0] exp_word);
    int n, low, sck_bad;
    logic [7:0] word;
    bit conv_seen;
    n = 0;
    conv_seen = 1'b0;
    while (amp_cs_n !== 1'b0 && n < 300) begin
      if (ad_conv === 1'b1) conv_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_cs_fall"}, 32'(n < 300), 32'd1);
    check({tag, "_before_conv"}, 32'(conv_seen), 32'd0);
    low = 0;
    sck_bad = 0;
    word = '0;
    while (amp_cs_n === 1'b0 && low < 200) begin
      if (spi_sck !== 1'((low / 4) % 2)) sck_bad++;
      if (low % 8 == 2) word = {word[6:0], spi_mosi};
      @(negedge clk);
      low++;
    end
    check({tag, "_cs_len"}, 32'(low), 32'd64);
    check({tag, "_word"}, 32'(word), 32'(exp_word));
    check({tag, "_sck"}, 32'(sck_bad), 32'd0);
    check({tag, "_done"}, 32'(gain_done), 32'd1);
    check({tag, "_mosi_idle"}, 32'(spi_mosi), 32'd0);
    $display("gain %s: word=%02h cs_low=%0d clks", tag, word, low);
  endtask

  // Run one conversion with the given ADC data; it can pulse gain_wr or reset partway through
  task automatic run_conv(input string tag, input int a, input int b, input logic [1:0] exp_wave,
                          input bit inject, input bit abort);
    int n, lat, cs_bad;
    logic [W-1:0] av, bv;
    av = a[W-1:0];
    bv = b[W-1:0];
    mdl_a = av;
    mdl_b = bv;
    n = 0;
    while (ad_conv !== 1'b1 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, 32'(n < 2500), 32'd1);
    if (n >= 2500) return;
    lat = 0;
    cs_bad = 0;
    while (sample_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
      gain_wr = (inject && lat == 100);
      if (amp_cs_n !== 1'b1) cs_bad++;
      if (abort && lat == 168) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_cs"}, 32'(amp_cs_n), 32'd1);
        check({tag, "_rst_conv"}, 32'(ad_conv), 32'd0);
        check({tag, "_rst_sck"}, 32'(spi_sck), 32'd0);
        check({tag, "_rst_mosi"}, 32'(spi_mosi), 32'd0);
        check({tag, "_rst_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_rst_a"}, 32'(sample_a), 32'd0);
        check({tag, "_rst_wave"}, 32'(wave), 32'd0);
        $display("conv %s: reset applied %0d clks after ad_conv", tag, lat);
        return;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd280);
    check({tag, "_a"}, 32'(sample_a), 32'(av));
    check({tag, "_b"}, 32'(sample_b), 32'(bv));
    check({tag, "_wave"}, 32'(wave), 32'(exp_wave));
    check({tag, "_cs_high"}, 32'(cs_bad), 32'd0);
    $display("conv %s: a=%0d b=%0d wave=%b latency=%0d", tag, $signed(sample_a), $signed(sample_b),
             wave, lat);
    @(negedge clk);
    check({tag, "_valid_pulse"}, 32'(sample_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rst2_n  = 1'b0;
    gain_wr = 1'b0;
    gain_a  = 4'h3;
    gain_b  = 4'h5;
    thr_hi  = 14'(4000);
    thr_lo  = 14'(-4000);
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(amp_cs_n), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_conv", 32'(ad_conv), 32'd0);
    check("rst_a", 32'(sample_a), 32'd0);
    check("rst_b", 32'(sample_b), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_wave", 32'(wave), 32'd0);
    check("rst_done", 32'(gain_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    $display("reset: outputs idle");
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    capture_gain("init", 8'h11);
    run_conv("c1", 0, -8192, 2'b00, 1'b0, 1'b0);
    check("ovr_early", 32'(overrun2), 32'd1);
    run_conv("c2", 4001, 5000, 2'b11, 1'b0, 1'b0);
    run_conv("c3_gainwr", 4000, 3000, 2'b11, 1'b1, 1'b0);
    capture_gain("req", 8'h53);
    run_conv("c4", -3999, -5000, 2'b01, 1'b0, 1'b0);
    run_conv("c5", -4001, 0, 2'b00, 1'b0, 1'b0);
    thr_hi = 14'(-100);
    thr_lo = 14'(100);
    run_conv("c6_swap", 0, 50, 2'b11, 1'b0, 1'b0);
    thr_hi = 14'(4000);
    thr_lo = 14'(-4000);
    run_conv("c7_full", 8191, -8192, 2'b01, 1'b0, 1'b0);
    run_conv("c8_abort", 1234, -1234, 2'b00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture_gain("reinit", 8'h11);
    run_conv("c9", 5000, -5000, 2'b01, 1'b0, 1'b0);

    check("main_overrun", 32'(overrun), 32'd0);
    check("ovr_sticky", 32'(overrun2), 32'd1);
    check("ovr_valid_seen", 32'(valid2_cnt > 1), 32'd1);
    check("ovr_sample_a", 32'(last_a2), 32'h3FFF);
    check("ovr_sample_b", 32'(last_b2), 32'h3FFF);
    $display("overrun instance: %0d samples, overrun=%b", valid2_cnt, overrun2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
